// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC cosine unit: fixed-point format, gain
// pre-scale, arctangent table and FSM state encoding.
package cordic_pkg;

  localparam int FRAC = 21;

  // round(0.6072529350 * 2^21)
  localparam logic signed [31:0] K_INIT = 32'sd1273502;

  // round(atan(2^-i) * 2^21), i = 0..31
  localparam logic signed [31:0] ATAN_TAB [32] = '{
    32'sd1647099, 32'sd972340, 32'sd513757, 32'sd260791,
    32'sd130902,  32'sd65515,  32'sd32765,  32'sd16384,
    32'sd8192,    32'sd4096,   32'sd2048,   32'sd1024,
    32'sd512,     32'sd256,    32'sd128,    32'sd64,
    32'sd32,      32'sd16,     32'sd8,      32'sd4,
    32'sd2,       32'sd1,      32'sd0,      32'sd0,
    32'sd0,       32'sd0,      32'sd0,      32'sd0,
    32'sd0,       32'sd0,      32'sd0,      32'sd0
  };

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_BUSY = 1'b1;

  // Re-express a constant held at FRAC fractional bits in another format.
  function automatic logic signed [31:0] rescale(input logic signed [31:0] v,
                                                 input int frac);
    if (frac >= FRAC) return v <<< (frac - FRAC);
    else              return v >>> (FRAC - frac);
  endfunction

  function automatic logic signed [31:0] atan_val(input logic [4:0] idx,
                                                  input int frac);
    return rescale(ATAN_TAB[idx], frac);
  endfunction

  function automatic logic signed [31:0] k_val(input int frac);
    return rescale(K_INIT, frac);
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// One combinational rotation-mode CORDIC micro-rotation.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int FRAC = cordic_pkg::FRAC
) (
  input  logic signed [31:0] x,
  input  logic signed [31:0] y,
  input  logic signed [31:0] z,
  input  logic        [4:0]  idx,
  output logic signed [31:0] x_next,
  output logic signed [31:0] y_next,
  output logic signed [31:0] z_next
);

  logic signed [31:0] x_sh;
  logic signed [31:0] y_sh;
  logic signed [31:0] angle;
  logic               pos;

  assign x_sh  = x >>> idx;
  assign y_sh  = y >>> idx;
  assign angle = atan_val(idx, FRAC);
  assign pos   = ~z[31];

  assign x_next = pos ? (x - y_sh)  : (x + y_sh);
  assign y_next = pos ? (y + x_sh)  : (y - x_sh);
  assign z_next = pos ? (z - angle) : (z + angle);

endmodule

// File: rtl/cordic_cos.sv
// Multi-cycle CORDIC cosine custom-instruction slave: float angle in,
// fixed-point cosine out, PER_CYCLE micro-rotations per enabled clock.
module cordic_cos
  import cordic_pkg::*;
#(
  parameter int ITER      = 20,
  parameter int PER_CYCLE = 5,
  parameter int FRAC      = cordic_pkg::FRAC
) (
  input  logic        clock,
  input  logic        aclr,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic [31:0] result,
  output logic        done
);

  localparam int NCYC = ITER / PER_CYCLE;
  localparam int CW   = $clog2(NCYC + 1);
  localparam logic [CW-1:0] LAST = CW'(NCYC);
  // Exponent at which {1,mantissa} needs no shift to land on FRAC bits.
  localparam logic [7:0] EXP_NOSHIFT = 8'(150 - FRAC);

  state_t             state;
  logic [CW-1:0]      count;
  logic signed [31:0] x_q, y_q, z_q;
  logic signed [31:0] z_load;
  logic [4:0]         base;

  logic signed [31:0] xs [PER_CYCLE+1];
  logic signed [31:0] ys [PER_CYCLE+1];
  logic signed [31:0] zs [PER_CYCLE+1];

  // cos is even, so the sign bit never reaches the datapath.
  logic unused_sign;
  assign unused_sign = dataa[31];

  logic [7:0]  exp_f;
  logic [31:0] mant;
  assign exp_f = dataa[30:23];
  assign mant  = {8'b0, 1'b1, dataa[22:0]};

  always_comb begin
    // NOTE: default first so every path assigns z_load and no latch is inferred.
    z_load = '0;
    if (exp_f != 8'd0) begin
      if (exp_f <= EXP_NOSHIFT) z_load = $signed(mant >> (EXP_NOSHIFT - exp_f));
      else                      z_load = $signed(mant << (exp_f - EXP_NOSHIFT));
    end
  end

  assign base  = 5'(int'(count) * PER_CYCLE);
  assign xs[0] = x_q;
  assign ys[0] = y_q;
  assign zs[0] = z_q;

  for (genvar k = 0; k < PER_CYCLE; k++) begin : g_stage
    cordic_stage #(.FRAC(FRAC)) u_stage (
      .x      (xs[k]),
      .y      (ys[k]),
      .z      (zs[k]),
      .idx    (base + 5'(k)),
      .x_next (xs[k+1]),
      .y_next (ys[k+1]),
      .z_next (zs[k+1])
    );
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr) begin
      state  <= ST_IDLE;
      count  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else if (clk_en) begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            x_q   <= k_val(FRAC);
            y_q   <= '0;
            z_q   <= z_load;
            count <= '0;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (count == LAST) begin
            result <= x_q;
            done   <= 1'b1;
            state  <= ST_IDLE;
          end else begin
            x_q   <= xs[PER_CYCLE];
            y_q   <= ys[PER_CYCLE];
            z_q   <= zs[PER_CYCLE];
            count <= count + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_cos.sv
// Directed self-checking bench for cordic_cos: accuracy, latency and control.
module tb_cordic_cos;

  localparam int TOL = 16;

  logic        clock  = 1'b0;
  logic        aclr   = 1'b0;
  logic        clk_en = 1'b1;
  logic        start  = 1'b0;
  logic [31:0] dataa  = '0;
  logic [31:0] result;
  logic        done;

  int compared   = 0;
  int mismatched = 0;
  int lat;
  int dones;

  cordic_cos #(.ITER(20), .PER_CYCLE(5), .FRAC(21)) dut (
    .clock  (clock),
    .aclr   (aclr),
    .clk_en (clk_en),
    .start  (start),
    .dataa  (dataa),
    .result (result),
    .done   (done)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] expected);
    compared++;
    assert (obs === expected) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expected);
    end
  endtask

  task automatic check_cos(input string tag, input int expected);
    int  obs;
    logic in_tol;
    obs    = $signed(result);
    in_tol = (^result !== 1'bx) && (obs - expected <= TOL) && (expected - obs <= TOL);
    compared++;
    assert (in_tol === 1'b1) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, expected, TOL);
    end
  endtask

  task automatic launch(input logic [31:0] a);
    dataa = a;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Count edges until done rises; 0 means it never came within the budget.
  task automatic wait_done(output int n_edges);
    n_edges = 0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (done === 1'b1) begin
        n_edges = n;
        break;
      end
    end
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      step();
      if (done === 1'b1) n++;
    end
  endtask

  task automatic run_cos(input string tag, input logic [31:0] a, input int expected);
    launch(a);
    wait_done(lat);
    check_eq({tag, "_latency"}, lat, 5);
    check_cos(tag, expected);
    step();
    check_eq({tag, "_done_pulse"}, {31'b0, done}, 0);
  endtask

  initial begin
    #22;
    check_eq("reset_result", result, 32'h0000_0000);
    check_eq("reset_done", {31'b0, done}, 0);
    @(negedge clock);
    aclr = 1'b1;
    step();

    run_cos("cos_zero",   32'h0000_0000, 2097152);
    run_cos("cos_denorm", 32'h0000_0001, 2097152);
    run_cos("cos_0p1",    32'h3DCC_CCCD, 2086675);
    run_cos("cos_0p5",    32'h3F00_0000, 32'h001C_1529);
    run_cos("cos_0p7",    32'h3F33_3333, 1603990);
    run_cos("cos_1p0",    32'h3F80_0000, 32'h0011_4A28);
    run_cos("cos_neg0p5", 32'hBF00_0000, 32'h001C_1529);

    // Back-to-back: next start issued in the cycle done is high.
    launch(32'h3E4C_CCCD);
    wait_done(lat);
    check_eq("b2b_first_latency", lat, 5);
    check_cos("cos_0p2", 2055349);
    launch(32'h3F66_6666);
    check_eq("b2b_done_low", {31'b0, done}, 0);
    wait_done(lat);
    check_eq("b2b_second_latency", lat, 5);
    check_cos("cos_0p9", 1303611);
    step();

    // Clock-enable stall of three cycles mid-operation.
    launch(32'h3F00_0000);
    step();
    step();
    clk_en = 1'b0;
    step();
    step();
    step();
    check_eq("stall_done_held_low", {31'b0, done}, 0);
    clk_en = 1'b1;
    wait_done(lat);
    check_eq("stall_latency", lat + 5, 8);
    check_cos("stall_cos_0p5", 32'h001C_1529);
    step();

    // Start pulsed while busy must be ignored.
    launch(32'h3F00_0000);
    step();
    dataa = 32'h3F80_0000;
    start = 1'b1;
    step();
    start = 1'b0;
    dataa = '0;
    wait_done(lat);
    check_eq("busy_start_latency", lat + 2, 5);
    check_cos("busy_start_cos", 32'h001C_1529);
    count_dones(12, dones);
    check_eq("busy_start_no_extra_done", dones, 0);

    // Reset mid-operation discards the work in flight.
    launch(32'h3F80_0000);
    step();
    step();
    aclr = 1'b0;
    #2;
    check_eq("midreset_result", result, 32'h0000_0000);
    check_eq("midreset_done", {31'b0, done}, 0);
    aclr = 1'b1;
    count_dones(10, dones);
    check_eq("midreset_no_done", dones, 0);
    check_eq("midreset_result_held", result, 32'h0000_0000);
    run_cos("after_reset_cos_0p5", 32'h3F00_0000, 32'h001C_1529);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
